// File: rtl/sdram_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_bist_pkg
// Description : Shared types, constants and helpers for the SDRAM BIST.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GEN     = 3'd1,
        WR_REQ  = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        NEXT    = 3'd5,
        DONE    = 3'd6
    } state_t;

    // Galois feedback mask for x^32 + x^22 + x^2 + x^1 + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam int c_MAX_W = 64;

    // Callers zero-extend into c_MAX_W and truncate the result to their data width.
    function automatic logic [c_MAX_W-1:0] expected_data(
        input logic [c_MAX_W-1:0] addr,
        input logic [c_MAX_W-1:0] xor_pat
    );
        return addr ^ xor_pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_bist_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : sdram_bist_lfsr
// Description : 32-bit right-shifting Galois LFSR with load and step controls.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_bist_lfsr
    import sdram_bist_pkg::*;
#(
    parameter logic [31:0] TAPS      = LFSR_TAPS,
    parameter logic [31:0] RESET_VAL = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_seed,
    input  logic        i_step,
    output logic [31:0] o_state
);

    logic [31:0] r_state;
    logic [31:0] w_next;

    assign w_next  = {1'b0, r_state[31:1]} ^ (r_state[0] ? TAPS : 32'h0000_0000);
    assign o_state = r_state;

    // Load has priority so a restart always begins from the seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RESET_VAL;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_step) begin
            r_state <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_bist.sv
`default_nettype none
// ============================================================================
// Module      : sdram_bist
// Description : Write/read-back traffic generator and checker for sdram_core.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_bist
    import sdram_bist_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    NUM_TESTS   = 1024,
    parameter logic [31:0]           ADDR_MASK   = 32'h00FF_FFFF,
    parameter logic [31:0]           LFSR_SEED   = 32'hACE1_0001,
    parameter logic [DATA_WIDTH-1:0] DATA_XOR    = DATA_WIDTH'(8'hA5),
    parameter int                    ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  wr,
    output logic                  rd,
    input  logic                  accept,
    input  logic                  ack,
    input  logic [DATA_WIDTH-1:0] read_data
);

    localparam int c_CNT_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
    localparam int c_TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_TEST = c_CNT_W'(NUM_TESTS - 1);
    localparam logic [c_TO_W-1:0]  c_LAST_TO   = c_TO_W'(ACK_TIMEOUT - 1);

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_TO_W-1:0]   r_tcnt;

    logic                  w_start_ok;
    logic [31:0]           w_lfsr_state;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [DATA_WIDTH-1:0] w_wdata_next;
    logic [DATA_WIDTH-1:0] w_exp;
    logic                  w_timeout;
    logic                  w_err_fire;
    logic                  w_wait_end;

    assign w_start_ok   = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_addr_next  = ADDR_WIDTH'(w_lfsr_state & ADDR_MASK);
    assign w_wdata_next = DATA_WIDTH'(expected_data(c_MAX_W'(w_addr_next), c_MAX_W'(DATA_XOR)));
    assign w_exp        = DATA_WIDTH'(expected_data(c_MAX_W'(addr), c_MAX_W'(DATA_XOR)));
    assign w_timeout    = (r_tcnt == c_LAST_TO);
    assign w_err_fire   = ack ? (read_data != w_exp) : w_timeout;
    assign w_wait_end   = ack || w_timeout;

    sdram_bist_lfsr #(
        .TAPS      (LFSR_TAPS),
        .RESET_VAL (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_start_ok),
        .i_seed  (LFSR_SEED),
        .i_step  (r_state == GEN),
        .o_state (w_lfsr_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_tcnt     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 16'h0000;
            err_addr   <= '0;
            addr       <= '0;
            write_data <= '0;
            wr         <= 1'b0;
            rd         <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count <= 16'h0000;
                        err_addr  <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= GEN;
                    end
                end
                GEN: begin
                    addr       <= w_addr_next;
                    write_data <= w_wdata_next;
                    wr         <= 1'b1;
                    r_state    <= WR_REQ;
                end
                WR_REQ: begin
                    if (accept) begin
                        wr         <= 1'b0;
                        write_data <= '0;
                        rd         <= 1'b1;
                        r_state    <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    // An ack arriving with the accept is ignored; the timeout covers it.
                    if (accept) begin
                        rd      <= 1'b0;
                        r_tcnt  <= '0;
                        r_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (w_wait_end) begin
                        if (w_err_fire) begin
                            if (err_count != 16'hFFFF) begin
                                err_count <= err_count + 16'h0001;
                            end
                            if (err_count == 16'h0000) begin
                                err_addr <= addr;
                            end
                        end
                        r_state <= NEXT;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (r_cnt == c_LAST_TEST) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_count == 16'h0000);
                        r_state <= DONE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= GEN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/sdram_bist.md
Name: sdram_bist

Overview:
Synthesizable traffic generator and checker that acts as the initiator on the sdram_core request/response interface. It drives writes and reads into sdram_core through the core-side interface (addr, write_data, wr, rd, accept, ack, read_data). For each of N pseudo-random addresses it writes an address-derived byte, reads it back and compares. It provides hardware self-test on the board in place of a simulation-only bench, and reports pass/fail, an error count and the first failing address.

Parameters:
ADDR_WIDTH, 32, width of the core interface address
DATA_WIDTH, 8, width of the core interface data
NUM_TESTS, 1024, number of write/read pairs per run (must be ≥1)
ADDR_MASK, 32'h00FF_FFFF, AND-mask applied to generated addresses to bound them to the part size
LFSR_SEED, 32'hACE1_0001, nonzero seed of the address LFSR
DATA_XOR, 8'hA5, pattern XORed into address-derived data
ACK_TIMEOUT, 255, cycles allowed between read accept and ack

Ports:
clk  in  1  system clock; same clock as sdram_core
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse that begins a run; ignored unless idle or done
busy  out  1  high from start until done
done  out  1  high after a run completes, held until the next start
pass  out  1  valid while done; 1 iff err_count==0
err_count  out  16  mismatches plus timeouts; saturates at 16'hFFFF
err_addr  out  ADDR_WIDTH  address of the first failure; 0 if none
addr  out  ADDR_WIDTH  request address
write_data  out  DATA_WIDTH  write payload
wr  out  1  write request
rd  out  1  read request
accept  in  1  controller has taken the current request
ack  in  1  read_data valid, one-cycle pulse
read_data  in  DATA_WIDTH  read return data

Behaviour:
- Reset (async): state IDLE; wr=rd=0; addr=0; write_data=0; busy=done=pass=0; err_count=0; err_addr=0; LFSR=LFSR_SEED; test counter=0.
- Handshake:
  - A request transfers on a rising edge where (wr|rd)&accept.
  - addr, write_data, wr and rd stay stable until that edge. They deassert (wr/rd=0, write_data=0) in the following cycle.
  - wr and rd are never high together.
  - ack is sampled only in RD_WAIT. A stray ack elsewhere is ignored.
- States:
  - IDLE: on start, clear err_count, err_addr and done; set busy=1; load LFSR=LFSR_SEED; counter=0 -> GEN.
  - GEN (1 cycle): addr <= LFSR & ADDR_MASK; write_data <= addr_next[DATA_WIDTH-1:0] ^ DATA_XOR; advance LFSR one step (Galois, taps 32,22,2,1) -> WR_REQ.
  - WR_REQ: wr=1. On accept -> RD_REQ (wr drops the next cycle).
  - RD_REQ: rd=1, same addr. On accept -> RD_WAIT; timeout counter=0.
  - RD_WAIT:
    - On ack: compare read_data with expected = addr[DATA_WIDTH-1:0]^DATA_XOR. On mismatch, err_count++ (saturating); if this is the first error, err_addr<=addr. -> NEXT.
    - If ack has not arrived after ACK_TIMEOUT cycles: count an error, latch err_addr if first, -> NEXT.
  - NEXT: counter++. If counter==NUM_TESTS-1 before the increment -> DONE, else -> GEN.
  - DONE: busy=0, done=1, pass=(err_count==0). Start -> same as in IDLE.
- start while busy: ignored.
- ack in the same cycle as the read accept: not possible with sdram_core. If it occurs it is ignored, and the timeout path handles the missing response.
- Repeated addresses from the LFSR after masking are permitted; each pair is self-contained.
- Reset mid-run: outputs return to reset values immediately. The controller sees wr/rd drop asynchronously and must tolerate it; a subsequent start restarts from LFSR_SEED.
- Latency per test with zero wait states:
  - GEN 1 cycle, WR 1, RD 1, plus ack latency, NEXT 1.
  - Minimum 4 cycles plus controller latency.

Decomposition:
- Package sdram_bist_pkg: state_t enum (IDLE, GEN, WR_REQ, RD_REQ, RD_WAIT, NEXT, DONE); LFSR_TAPS constant 32'h8020_0003; function expected_data(addr, xor_pat).
- Sub-module sdram_bist_lfsr: 32-bit Galois LFSR with load, seed and step inputs. It is reused by later traffic generators.

Test Plan:
- Behavioural responder (accept=1 every cycle, ack 3 cycles after read accept, returns the last written byte for the address), NUM_TESTS=4, start pulse -> 4 wr and 4 rd transfers, alternating wr/rd, done=1, pass=1, err_count=0, busy low at done.
- Responder holds accept=0 for 5 cycles on the first write -> wr and addr stable for all 6 cycles, exactly one write transfer, run passes.
- Responder inverts bit 0 of read_data on the 2nd read, NUM_TESTS=4 -> err_count=1, err_addr = 2nd generated address (LFSR step 2 & ADDR_MASK), pass=0.
- Responder never acks, ACK_TIMEOUT=10, NUM_TESTS=3 -> each read waits 10 cycles, err_count=3, err_addr = first address, done=1.
- Assert rst mid-WR_REQ, then start again -> wr=0 immediately; the first address after restart equals the first address of a fresh run (LFSR_SEED & ADDR_MASK).
- Full system with sdram_core plus the MT48LC8M16A2 model at 50 MHz, NUM_TESTS=16 -> pass=1, err_count=0.
